// File: rtl/tick_scheduler.sv
// Game-tick generator and two-player move sequencer: each tick serves both
// players once, in alternating order, through a req/ack handshake.
module tick_scheduler #(
  parameter int TICK_DIV = 4_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] dir_a,
  input  logic [1:0] dir_b,
  output logic       tick,
  output logic       move_req,
  output logic       move_player,
  output logic [1:0] move_dir,
  input  logic       move_ack,
  output logic       busy,
  output logic       overrun,
  output logic       frame_done
);

  localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  // Encoding UP=0, DOWN=1, LEFT=2, RIGHT=3: opposites differ only in bit 0.
  localparam logic [1:0] DIR_UP   = 2'd0;
  localparam logic [1:0] DIR_DOWN = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE_FIRST,
    ST_SERVE_SECOND,
    ST_DONE
  } state_t;

  state_t        state_reg,       state_next;
  logic [CW-1:0] counter_reg,     counter_next;
  logic          tick_reg,        tick_next;
  logic          move_req_reg,    move_req_next;
  logic          move_player_reg, move_player_next;
  logic [1:0]    move_dir_reg,    move_dir_next;
  logic          overrun_reg,     overrun_next;
  logic          first_b_reg,     first_b_next;
  logic [1:0]    snap_a_reg,      snap_a_next;
  logic [1:0]    snap_b_reg,      snap_b_next;
  logic [1:0]    last_a_reg,      last_a_next;
  logic [1:0]    last_b_reg,      last_b_next;
  logic          tick_now;

  function automatic logic [1:0] filter_dir(input logic [1:0] want, input logic [1:0] last);
    return (want == (last ^ 2'b01)) ? last : want;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_reg     <= '0;
      tick_reg        <= 1'b0;
      move_req_reg    <= 1'b0;
      move_player_reg <= 1'b0;
      move_dir_reg    <= DIR_UP;
      overrun_reg     <= 1'b0;
      first_b_reg     <= 1'b0;
      snap_a_reg      <= DIR_UP;
      snap_b_reg      <= DIR_DOWN;
      last_a_reg      <= DIR_UP;
      last_b_reg      <= DIR_DOWN;
    end else begin
      counter_reg     <= counter_next;
      tick_reg        <= tick_next;
      move_req_reg    <= move_req_next;
      move_player_reg <= move_player_next;
      move_dir_reg    <= move_dir_next;
      overrun_reg     <= overrun_next;
      first_b_reg     <= first_b_next;
      snap_a_reg      <= snap_a_next;
      snap_b_reg      <= snap_b_next;
      last_a_reg      <= last_a_next;
      last_b_reg      <= last_b_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    counter_next     = counter_reg;
    move_req_next    = move_req_reg;
    move_player_next = move_player_reg;
    move_dir_next    = move_dir_reg;
    overrun_next     = overrun_reg;
    first_b_next     = first_b_reg;
    snap_a_next      = snap_a_reg;
    snap_b_next      = snap_b_reg;
    last_a_next      = last_a_reg;
    last_b_next      = last_b_reg;

    tick_now  = enable && (counter_reg == CNT_LAST);
    tick_next = tick_now;
    if (enable) begin
      counter_next = (counter_reg == CNT_LAST) ? '0 : counter_reg + CW'(1);
    end

    if (tick_now && (state_reg != ST_IDLE)) begin
      overrun_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        // Raw inputs equal the snapshot being latched on this same edge.
        if (tick_now) begin
          snap_a_next      = dir_a;
          snap_b_next      = dir_b;
          state_next       = ST_SERVE_FIRST;
          move_req_next    = 1'b1;
          move_player_next = first_b_reg;
          move_dir_next    = first_b_reg ? filter_dir(dir_b, last_b_reg)
                                         : filter_dir(dir_a, last_a_reg);
        end
      end
      ST_SERVE_FIRST: begin
        if (move_req_reg && move_ack) begin
          if (move_player_reg) last_b_next = move_dir_reg;
          else                 last_a_next = move_dir_reg;
          move_req_next = 1'b0;
          state_next    = ST_SERVE_SECOND;
        end
      end
      ST_SERVE_SECOND: begin
        if (!move_req_reg) begin
          move_req_next    = 1'b1;
          move_player_next = ~first_b_reg;
          move_dir_next    = first_b_reg ? filter_dir(snap_a_reg, last_a_reg)
                                         : filter_dir(snap_b_reg, last_b_reg);
        end else if (move_ack) begin
          if (move_player_reg) last_b_next = move_dir_reg;
          else                 last_a_next = move_dir_reg;
          move_req_next = 1'b0;
          state_next    = ST_DONE;
        end
      end
      default: begin
        first_b_next = ~first_b_reg;
        state_next   = ST_IDLE;
      end
    endcase
  end

  assign tick        = tick_reg;
  assign move_req    = move_req_reg;
  assign move_player = move_player_reg;
  assign move_dir    = move_dir_reg;
  assign overrun     = overrun_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign frame_done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: a queue-based service model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tick_scheduler;

  localparam int TICK_DIV = 4;
  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] dir_a = UP;
  logic [1:0] dir_b = UP;
  logic       move_ack = 1'b0;
  logic       tick, move_req, move_player, busy, overrun, frame_done;
  logic [1:0] move_dir;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tick_scheduler #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dir_a(dir_a), .dir_b(dir_b),
    .tick(tick), .move_req(move_req), .move_player(move_player), .move_dir(move_dir),
    .move_ack(move_ack), .busy(busy), .overrun(overrun), .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: pending services form a queue; a gap cycle follows the first ack,
  // a frame_done cycle follows the last ack.
  typedef struct packed { logic p; logic [1:0] d; } svc_t;
  svc_t       svc_q[$];
  int         m_cnt;
  bit         m_tick, m_gap, m_done, m_over, m_first_b;
  logic [1:0] m_last_a, m_last_b;

  function automatic logic [1:0] applied(input logic [1:0] want, input logic [1:0] last);
    logic [1:0] opp;
    case (last)
      UP:      opp = DOWN;
      DOWN:    opp = UP;
      LEFT:    opp = RIGHT;
      default: opp = LEFT;
    endcase
    return (want == opp) ? last : want;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_tick = 0; m_gap = 0; m_done = 0; m_over = 0; m_first_b = 0;
    m_last_a = UP; m_last_b = DOWN;
    svc_q.delete();
  endtask

  task automatic push_svc(input logic p);
    svc_t s;
    s.p = p;
    s.d = p ? applied(dir_b, m_last_b) : applied(dir_a, m_last_a);
    svc_q.push_back(s);
  endtask

  task automatic model_step();
    bit tick_now, req_pre, done_pre, idle;
    tick_now = enable && (m_cnt == TICK_DIV - 1);
    if (enable) m_cnt = (m_cnt + 1) % TICK_DIV;
    req_pre  = (svc_q.size() != 0) && !m_gap;
    done_pre = m_done;
    idle     = (svc_q.size() == 0) && !m_done;
    m_tick = tick_now;
    m_gap  = 0;
    m_done = 0;
    if (done_pre) m_first_b = !m_first_b;
    if (req_pre && move_ack) begin
      $display("served player %0d dir %0d at %0t", svc_q[0].p, svc_q[0].d, $time);
      if (svc_q[0].p) m_last_b = svc_q[0].d;
      else            m_last_a = svc_q[0].d;
      void'(svc_q.pop_front());
      if (svc_q.size() == 0) m_done = 1;
      else                   m_gap = 1;
    end
    if (tick_now) begin
      if (idle) begin
        push_svc(m_first_b);
        push_svc(!m_first_b);
      end else begin
        m_over = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin : compare
    bit e_req;
    forever begin
      @(negedge clk);
      e_req = (svc_q.size() != 0) && !m_gap;
      chk("tick", tick, m_tick);
      chk("move_req", move_req, e_req);
      chk("busy", busy, (svc_q.size() != 0) || m_done);
      chk("overrun", overrun, m_over);
      chk("frame_done", frame_done, m_done);
      if (e_req) begin
        chk("move_player", move_player, svc_q[0].p);
        chk("move_dir", move_dir, svc_q[0].d);
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset with the given inputs; returns at the negedge where rst_n releases.
  task automatic start(input logic en, input logic [1:0] a, input logic [1:0] b, input logic ack);
    @(negedge clk);
    #2 rst_n = 1'b0;
    enable = en; dir_a = a; dir_b = b; move_ack = ack;
    wait_edges(2);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_req"}, move_req, 0);
    chk({tag, "_player"}, move_player, 0);
    chk({tag, "_dir"}, move_dir, UP);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_reset_values("rst0");

    // Ticks every 4 cycles, ack tied high, A then B, then B first.
    enable = 1'b1; dir_a = LEFT; dir_b = RIGHT; move_ack = 1'b1;
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(3); chk("t1_tick_e3", tick, 0);
    wait_edges(1); chk("t1_tick_e4", tick, 1); chk("t1_req_e4", move_req, 1);
                   chk("t1_player_e4", move_player, 0); chk("t1_dir_e4", move_dir, LEFT);
    wait_edges(1); chk("t1_tick_e5", tick, 0); chk("t1_gap_e5", move_req, 0);
    wait_edges(1); chk("t1_req_e6", move_req, 1); chk("t1_player_e6", move_player, 1);
                   chk("t1_dir_e6", move_dir, RIGHT);
    wait_edges(1); chk("t1_done_e7", frame_done, 1);
    wait_edges(1); chk("t1_tick_e8", tick, 1); chk("t1_over_e8", overrun, 1);
                   chk("t1_req_e8", move_req, 0);
    wait_edges(4); chk("t1_tick_e12", tick, 1); chk("t1_player_e12", move_player, 1);
                   chk("t1_dir_e12", move_dir, RIGHT);
    wait_edges(4);

    // Reversal filter for A after reset, then a legal turn.
    start(1'b1, DOWN, DOWN, 1'b1);
    wait_edges(4); chk("t2_player_e4", move_player, 0); chk("t2_dir_e4", move_dir, UP);
    wait_edges(2); chk("t2_player_e6", move_player, 1); chk("t2_dir_e6", move_dir, DOWN);
    dir_a = LEFT;
    wait_edges(6); chk("t2_player_e12", move_player, 1); chk("t2_dir_e12", move_dir, DOWN);
    wait_edges(2); chk("t2_player_e14", move_player, 0); chk("t2_dir_e14", move_dir, LEFT);
    wait_edges(3);

    // Stalled ack: request holds, tick overruns, B reversal rejected.
    start(1'b1, RIGHT, UP, 1'b0);
    wait_edges(4); chk("t3_req_e4", move_req, 1); chk("t3_over_e4", overrun, 0);
    wait_edges(4); chk("t3_over_e8", overrun, 1); chk("t3_req_e8", move_req, 1);
                   chk("t3_dir_e8", move_dir, RIGHT);
    wait_edges(6); chk("t3_req_e14", move_req, 1); chk("t3_player_e14", move_player, 0);
                   chk("t3_dir_e14", move_dir, RIGHT);
    move_ack = 1'b1;
    wait_edges(1); chk("t3_gap_e15", move_req, 0);
    wait_edges(1); chk("t3_player_e16", move_player, 1); chk("t3_dir_e16", move_dir, DOWN);
    wait_edges(1); chk("t3_done_e17", frame_done, 1);
    wait_edges(4);

    // Enable dropped in SERVE_FIRST: sequence completes, counter holds at 2.
    start(1'b1, LEFT, LEFT, 1'b0);
    wait_edges(4); chk("t4_req_e4", move_req, 1);
    wait_edges(2);
    enable = 1'b0; move_ack = 1'b1;
    wait_edges(2); chk("t4_player_e8", move_player, 1); chk("t4_dir_e8", move_dir, LEFT);
    wait_edges(1); chk("t4_done_e9", frame_done, 1);
    wait_edges(5); chk("t4_over_e14", overrun, 0); chk("t4_busy_e14", busy, 0);
    enable = 1'b1;
    wait_edges(1); chk("t4_tick_e15", tick, 0);
    wait_edges(1); chk("t4_tick_e16", tick, 1); chk("t4_player_e16", move_player, 1);
    wait_edges(4);

    // Asynchronous reset during SERVE_SECOND.
    start(1'b1, UP, LEFT, 1'b1);
    wait_edges(14); chk("t5_req_e14", move_req, 1); chk("t5_over_e14", overrun, 1);
                    chk("t5_busy_e14", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_values("t5_async");
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(4); chk("t5_req_after", move_req, 1); chk("t5_player_after", move_player, 0);
                   chk("t5_dir_after", move_dir, UP);
    wait_edges(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
